// File: rtl/onebit_sram_seq.sv
// onebit_sram_seq
// Access sequencer for a single SRAM bitcell and its sense amplifier.
// Turns one-cycle op requests into timed precharge / write / evaluate
// phases, captures the sensed value and reports it with a one-cycle strobe.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        request strobe, taken only while ready=1
//   op[1:0]    00 write, 01 read Q, 10 read QB, 11 read-check (Q then QB)
//   wdata      write data for op 00
//   sa_out     sense-amp output, sampled at the end of the last evaluate cycle
//   ready      high only while idle
//   rsp_valid  one-cycle completion pulse per accepted op
//   rdata      last sensed Q (op 01/11) or QB (op 10) value
//   chk_err    op 11: Q and QB samples were equal
//   preb, w_en, write_bit, SAE, WL, WLB   registered cell controls
module onebit_sram_seq #(
  parameter int T_PRE  = 2,
  parameter int T_EVAL = 3,
  parameter int T_WR   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [1:0] op,
  input  logic       wdata,
  input  logic       sa_out,
  output logic       ready,
  output logic       rsp_valid,
  output logic       rdata,
  output logic       chk_err,
  output logic       preb,
  output logic       w_en,
  output logic       write_bit,
  output logic       SAE,
  output logic       WL,
  output logic       WLB
);

  localparam int TMAX_A = (T_PRE > T_EVAL) ? T_PRE : T_EVAL;
  localparam int TMAX   = (TMAX_A > T_WR) ? TMAX_A : T_WR;
  localparam int CW     = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, WR, PRE, EVAL, RSP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    op_q, op_n;
  logic          second, second_n;
  logic          q_sample;
  logic          accept, last_eval;
  logic          preb_n, w_en_n, sae_n, wl_n, wlb_n, rsp_n;

  assign ready     = (state == IDLE);
  assign accept    = (state == IDLE) && req;
  assign op_n      = accept ? op : op_q;
  assign last_eval = (state == EVAL) && (cnt == '0);

  // Next-state logic. The phase counter is loaded with length-1 on entry to
  // each timed state and the state advances when it reaches zero. For a
  // read-check, 'second' marks the QB half so the first evaluate loops back
  // through a fresh precharge instead of finishing.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    second_n = second;
    case (state)
      IDLE: begin
        if (req) begin
          if (op == 2'b00) begin
            state_n = WR;
            cnt_n   = CW'(T_WR - 1);
          end else begin
            state_n  = PRE;
            cnt_n    = CW'(T_PRE - 1);
            second_n = 1'b0;
          end
        end
      end
      WR: begin
        if (cnt == '0) state_n = RSP;
        else           cnt_n   = cnt - CW'(1);
      end
      PRE: begin
        if (cnt == '0) begin
          state_n = EVAL;
          cnt_n   = CW'(T_EVAL - 1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      EVAL: begin
        if (cnt == '0) begin
          if (op_q == 2'b11 && !second) begin
            state_n  = PRE;
            cnt_n    = CW'(T_PRE - 1);
            second_n = 1'b1;
          end else begin
            state_n = RSP;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RSP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Cell-control decode from the upcoming state, so the control flops line
  // up exactly with the state they belong to. Precharge and idle leave every
  // control low, which keeps the bitlines precharged (preb active-low).
  always_comb begin
    preb_n = 1'b0;
    w_en_n = 1'b0;
    sae_n  = 1'b0;
    wl_n   = 1'b0;
    wlb_n  = 1'b0;
    rsp_n  = (state_n == RSP);
    case (state_n)
      WR: begin
        preb_n = 1'b1;
        w_en_n = 1'b1;
        wl_n   = 1'b1;
        wlb_n  = 1'b1;
      end
      EVAL: begin
        preb_n = 1'b1;
        sae_n  = 1'b1;
        if (op_n == 2'b10 || (op_n == 2'b11 && second_n)) wlb_n = 1'b1;
        else                                               wl_n  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, phase counter and read-check half flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      second <= 1'b0;
      op_q   <= 2'b00;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      second <= second_n;
      op_q   <= op_n;
    end
  end

  // Registered outputs and sense capture. write_bit doubles as the latched
  // write data and holds after the write; only w_en gates the cell write.
  // sa_out is looked at solely on the edge ending the final evaluate cycle.
  // The Q half of a read-check is parked in q_sample and only published to
  // rdata together with the compare result at the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preb      <= 1'b0;
      w_en      <= 1'b0;
      write_bit <= 1'b0;
      SAE       <= 1'b0;
      WL        <= 1'b0;
      WLB       <= 1'b0;
      rsp_valid <= 1'b0;
      rdata     <= 1'b0;
      chk_err   <= 1'b0;
      q_sample  <= 1'b0;
    end else begin
      preb      <= preb_n;
      w_en      <= w_en_n;
      SAE       <= sae_n;
      WL        <= wl_n;
      WLB       <= wlb_n;
      rsp_valid <= rsp_n;
      if (accept && op == 2'b00) write_bit <= wdata;
      if (last_eval) begin
        if (op_q == 2'b11 && !second) begin
          q_sample <= sa_out;
        end else if (op_q == 2'b11) begin
          rdata   <= q_sample;
          chk_err <= (q_sample == sa_out);
        end else begin
          rdata   <= sa_out;
          chk_err <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/onebit_sram_seq.md
Name: onebit_sram_seq

Overview:
- Synthesizable access sequencer that drives one SRAM bitcell and its sense amp.
- Controls driven: preb, w_en, write_bit, SAE, WL, WLB.
- Turns single-cycle op requests into timed precharge / write / evaluate phases.
- Captures the sense-amp result and returns it with a one-cycle response strobe. Sits directly upstream of the bitcell/SA macro.

Parameters:
- T_PRE, 2, precharge phase length in cycles (preb=0); legal ≥1.
- T_EVAL, 3, read evaluate phase length in cycles (WL or WLB, preb=1, SAE=1); legal ≥1.
- T_WR, 2, write phase length in cycles (WL=WLB=1, w_en=1); legal ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  request strobe; accepted only when ready=1.
- op  in  2  00 write, 01 read Q, 10 read QB, 11 read-check (Q then QB).
- wdata  in  1  write data, used for op=00.
- sa_out  in  1  sense-amp output from the cell macro; valid during evaluate.
- ready  out  1  high only in IDLE.
- rsp_valid  out  1  one-cycle completion pulse, every accepted op.
- rdata  out  1  last sensed Q value (op 01/11) or QB value (op 10).
- chk_err  out  1  op 11 only: 1 if the Q and QB samples are equal (non-complementary).
- preb, w_en, write_bit, SAE, WL, WLB  out  1 each  cell controls, all registered.

Behaviour:
- Reset values (asynchronous, immediate):
  - preb=0, w_en=0, write_bit=0, SAE=0, WL=0, WLB=0.
  - rsp_valid=0, rdata=0, chk_err=0.
  - State=IDLE, so ready=1.
- Idle drive: preb=0 (bitlines precharged); all other cell controls 0.
- Acceptance: req&ready at rising edge E0 latches op and wdata. Later changes are ignored until the next acceptance.
- req while ready=0 is dropped; there is no queueing.
- States: IDLE, WR, PRE, EVAL, RSP. A phase counter of width $clog2(max(T_*)+1) is reloaded on each state entry.
- Write (op=00):
  - WR for T_WR cycles: WL=1, WLB=1, preb=1, w_en=1, write_bit=latched wdata.
  - Then RSP.
  - rsp_valid is asserted in cycle T_WR+1 after E0; rdata and chk_err are unchanged.
- Read (op=01/10):
  - PRE for T_PRE cycles: all controls idle.
  - EVAL for T_EVAL cycles: preb=1, SAE=1, and WL=1 (op 01) or WLB=1 (op 10).
  - sa_out is sampled at the edge ending the last EVAL cycle.
  - RSP: rsp_valid=1 and rdata=sample, in cycle T_PRE+T_EVAL+1 after E0.
- Read-check (op=11):
  - Sequence: PRE, EVAL(WL), PRE, EVAL(WLB), RSP.
  - rdata = Q sample; chk_err = (Q sample == QB sample).
  - rsp_valid is asserted in cycle 2*(T_PRE+T_EVAL)+1.
  - For ops 01/10, chk_err is cleared to 0 at RSP.
- Exclusivity invariants, every cycle:
  - w_en=1 implies preb=1, WL=1, WLB=1, SAE=0.
  - SAE=1 implies exactly one of WL/WLB is high, and w_en=0.
  - WL=WLB=1 never occurs outside WR.
- State after RSP: always returns to IDLE. ready rises in the cycle after rsp_valid, and the earliest next accept is at that edge.
- Sense data: write_bit is held at its value after WR; only w_en gates the write. sa_out is ignored outside the final EVAL cycle.
- Reset mid-operation: the op is aborted with no rsp_valid and all outputs return to reset values at once. After rst_n deasserts, the block is in IDLE with ready=1 on the first edge.
- rst_n deassertion is synchronised externally.

Test Plan:
- Reset with defaults, rst_n=0 mid-cycle → all cell controls 0 (preb=0), ready=1, rsp_valid=0, rdata=0, chk_err=0 without a clock edge.
- Write 1 (op=00, wdata=1) at E0 → cycles 1-2: WL=WLB=preb=w_en=write_bit=1. Cycle 3: rsp_valid=1 with cell controls idle. Cycle 4: ready=1.
- Read Q with sa_out=1 during EVAL (op=01) → cycles 1-2 preb=0; cycles 3-5 WL=1, SAE=1, preb=1, WLB=0. Cycle 6: rsp_valid=1, rdata=1.
- Read-check (op=11) with sa_out=1 on the Q evaluate and 0 on the QB evaluate → rsp_valid in cycle 11, rdata=1, chk_err=0. Repeat with sa_out=1 on both → chk_err=1.
- Request while busy: req with op=10 asserted every cycle during a write → only the first op executes. The next op is accepted at the edge where ready=1, with exactly one rsp_valid per accepted op.
- Reset asserted in cycle 4 of a read → outputs go to reset values immediately and no rsp_valid occurs. A new read accepted afterwards completes normally.
